// File: rtl/qr_acc_pkg.sv
// Shared FSM state type, comparator-count helper and accumulator
// sign-extend/saturate function for the QR bit-serial MAC.
package qr_acc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } qr_state_e;

    localparam int QR_ADC_BITS_DEF = 4;
    localparam int QR_NUM_CMP      = (1 << QR_ADC_BITS_DEF) - 1;

    function automatic int cmp_count(input int adc_bits);
        return (1 << adc_bits) - 1;
    endfunction

    // Fits a wide intermediate into a bits-wide signed range, either by
    // clamping or by two's-complement wrap (sign-extend from bit bits-1).
    function automatic logic signed [63:0] acc_fit(input logic signed [63:0] v,
                                                   input int                 bits,
                                                   input logic               sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (sat) begin
            if (v > hi) return hi;
            if (v < lo) return lo;
            return v;
        end
        return (v <<< (64 - bits)) >>> (64 - bits);
    endfunction

endpackage

// File: rtl/qr_adc_therm_decoder.sv
// Combinational thermometer-to-signed-code decoder for one ADC column.
// The highest set comparator wins; bubbles below it are ignored.
module qr_adc_therm_decoder
    import qr_acc_pkg::*;
#(
    parameter int numAdcBits = QR_ADC_BITS_DEF
) (
    input  logic [(2**numAdcBits)-2:0]   therm,
    output logic signed [numAdcBits-1:0] code
);

    localparam int NCMP = cmp_count(numAdcBits);
    localparam int HALF = 1 << (numAdcBits - 1);

    always_comb begin
        code = numAdcBits'(-HALF);
        for (int i = 0; i < NCMP; i++) begin
            if (therm[i]) code = numAdcBits'(i + 1 - HALF);
        end
    end

endmodule

// File: rtl/qr_bitserial_mac.sv
// Bit-serial MAC sequencer for the analog QR array: drives one input
// bit-plane per PRE/EVAL pair, MSB first, and shift-accumulates the decoded
// ADC result per column. Define QR_MAC_SAT_EN to saturate instead of wrap.
//
//   state | meaning
//   IDLE  | ready for an input vector, analog pins at rest
//   PRE   | all rows to VRST, ADC precharge (NF=1, R2A=1)
//   EVAL  | rows driven by the current plane, ADC evaluates (M2A=1)
//   DONE  | result held on out_data_o until out_ready_i
module qr_bitserial_mac
    import qr_acc_pkg::*;
#(
    parameter int numRows      = 128,
    parameter int numCols      = 8,
    parameter int numAdcBits   = 4,
    parameter int maxInputBits = 8,
    parameter int accBits      = 16
) (
    input  logic                                    clk,
    input  logic                                    nrst,
    input  logic [$clog2(maxInputBits):0]           n_input_bits_cfg,
    input  logic                                    signed_cfg,
    input  logic                                    binary_cfg,
    input  logic                                    in_valid_i,
    output logic                                    in_ready_o,
    input  logic [numRows*maxInputBits-1:0]         in_data_i,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [numCols*accBits-1:0]              out_data_o,
    output logic                                    busy_o,
    output logic [numRows-1:0]                      VDR_SEL,
    output logic [numRows-1:0]                      VDR_SELB,
    output logic [numRows-1:0]                      VSS_SEL,
    output logic [numRows-1:0]                      VSS_SELB,
    output logic [numRows-1:0]                      VRST_SEL,
    output logic [numRows-1:0]                      VRST_SELB,
    output logic                                    NF,
    output logic                                    NFB,
    output logic                                    R2A,
    output logic                                    R2AB,
    output logic                                    M2A,
    output logic                                    M2AB,
    input  logic [numCols*((2**numAdcBits)-1)-1:0]  ADC_OUT
);

    localparam int NCMP = cmp_count(numAdcBits);
    localparam int NW   = $clog2(maxInputBits) + 1;
    localparam int PW   = (maxInputBits > 1) ? $clog2(maxInputBits) : 1;

`ifdef QR_MAC_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    qr_state_e state_q, state_d;

    logic [maxInputBits-1:0] data_q [numRows];
    logic [PW-1:0]           plane_q;
    logic                    signed_q;
    logic                    binary_q;
    logic                    first_q;
    logic [NW-1:0]           n_clamp;
    logic [numRows-1:0]      plane_bits;
    logic                    accept;

    logic [numRows-1:0]      vdr_d, vss_d, vrst_d;
    logic                    nf_d, r2a_d, m2a_d;

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = (state_q == DONE);
    assign accept      = in_valid_i && in_ready_o;

    always_comb begin
        n_clamp = n_input_bits_cfg;
        if (n_input_bits_cfg == '0) begin
            n_clamp = NW'(1);
        end else if (n_input_bits_cfg > NW'(maxInputBits)) begin
            n_clamp = NW'(maxInputBits);
        end
    end

    always_comb begin
        plane_bits = '0;
        for (int r = 0; r < numRows; r++) begin
            plane_bits[r] = data_q[r][plane_q];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Analog outputs are computed from the next state and registered, so the
    // switch matrix never sees a combinational glitch.
    always_comb begin
        state_d = state_q;
        vdr_d   = '0;
        vss_d   = '0;
        vrst_d  = '1;
        nf_d    = 1'b0;
        r2a_d   = 1'b0;
        m2a_d   = 1'b1;
        unique case (state_q)
            IDLE:    if (in_valid_i) state_d = PRE;
            PRE:     state_d = EVAL;
            EVAL:    state_d = (plane_q == '0) ? DONE : PRE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == PRE) begin
            nf_d  = 1'b1;
            r2a_d = 1'b1;
            m2a_d = 1'b0;
        end else if (state_d == EVAL) begin
            vdr_d  = plane_bits;
            vss_d  = binary_q ? '0 : ~plane_bits;
            vrst_d = binary_q ? ~plane_bits : '0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            VDR_SEL  <= '0;
            VSS_SEL  <= '0;
            VRST_SEL <= '1;
            NF       <= 1'b0;
            R2A      <= 1'b0;
            M2A      <= 1'b1;
        end else begin
            VDR_SEL  <= vdr_d;
            VSS_SEL  <= vss_d;
            VRST_SEL <= vrst_d;
            NF       <= nf_d;
            R2A      <= r2a_d;
            M2A      <= m2a_d;
        end
    end

    assign VDR_SELB  = ~VDR_SEL;
    assign VSS_SELB  = ~VSS_SEL;
    assign VRST_SELB = ~VRST_SEL;
    assign NFB       = ~NF;
    assign R2AB      = ~R2A;
    assign M2AB      = ~M2A;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int r = 0; r < numRows; r++) data_q[r] <= '0;
            plane_q  <= '0;
            signed_q <= 1'b0;
            binary_q <= 1'b0;
            first_q  <= 1'b0;
        end else if (accept) begin
            for (int r = 0; r < numRows; r++) begin
                data_q[r] <= in_data_i[r*maxInputBits +: maxInputBits];
            end
            plane_q  <= PW'(n_clamp - NW'(1));
            signed_q <= signed_cfg;
            binary_q <= binary_cfg;
            first_q  <= 1'b1;
        end else if (state_q == EVAL) begin
            first_q <= 1'b0;
            if (plane_q != '0) plane_q <= plane_q - PW'(1);
        end
    end

    for (genvar g = 0; g < numCols; g++) begin : g_col
        logic signed [numAdcBits-1:0] code;
        logic signed [63:0]           code_w;
        logic signed [63:0]           acc_w;
        logic signed [63:0]           step_w;
        logic signed [accBits-1:0]    acc_q;
        logic signed [accBits-1:0]    acc_d;

        qr_adc_therm_decoder #(
            .numAdcBits(numAdcBits)
        ) u_dec (
            .therm(ADC_OUT[g*NCMP +: NCMP]),
            .code (code)
        );

        // MSB plane carries negative weight for two's-complement inputs.
        always_comb begin
            code_w = 64'(code);
            acc_w  = 64'(acc_q);
            if (first_q) begin
                step_w = signed_q ? -code_w : code_w;
            end else begin
                step_w = (acc_w <<< 1) + code_w;
            end
            acc_d = accBits'(acc_fit(step_w, accBits, SAT_EN));
        end

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                acc_q <= '0;
            end else if (accept) begin
                acc_q <= '0;
            end else if (state_q == EVAL) begin
                acc_q <= acc_d;
            end
        end

        assign out_data_o[g*accBits +: accBits] = (state_q == DONE) ? acc_q : '0;
    end

endmodule
